// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the fetch port, the data port and the memory-side bus of the
// unified-memory arbiter.
//   slave  modport : the arbiter itself. It takes the port requests and the
//                    memory read data, and returns done/rdata, the memory
//                    strobe/address/data, stall and err.
//   master modport : the requesters plus the memory macro, which together
//                    drive the other end of every signal.
// Fetch port : if_req, if_addr -> if_rdata, if_done
// Data port  : d_rd, d_wr, d_addr, d_wdata -> d_rdata, d_done
// Memory bus : mem_en, mem_wr, mem_addr, mem_wdata <- mem_rdata
// Status     : stall (combinational), err (registered pulse)
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;

    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;

    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        stall;
    logic        err;

    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done,
        output mem_en, mem_wr, mem_addr, mem_wdata, stall, err
    );

    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done,
        input  mem_en, mem_wr, mem_addr, mem_wdata, stall, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-ported, fixed-latency memory between the instruction
// fetch port and the data port. The data port has fixed priority, and a
// grant is never pre-empted. Each access runs IDLE -> BUSY_x -> DONE, so
// the block completes one access every MEM_LAT+3 cycles.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : mem_arbiter_if.slave. It carries the fetch and data request
//          ports, the memory bus, the combinational stall output and the
//          registered err pulse.
// Parameter:
//   MEM_LAT : number of cycles from mem_en to valid mem_rdata (1..15)
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_D  = 2'd1,
        BUSY_IF = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic        owner_d_reg;
    logic        err_seen_reg;

    logic        mem_en_reg;
    logic        mem_wr_reg;
    logic [15:0] mem_addr_reg;
    logic [15:0] mem_wdata_reg;
    logic [15:0] if_rdata_reg;
    logic [15:0] d_rdata_reg;
    logic        if_done_reg;
    logic        d_done_reg;
    logic        err_reg;

    logic        d_any;
    logic        grant_d;
    logic        grant_if;
    logic        capture;
    logic        err_next;

    assign d_any = bus.d_rd | bus.d_wr;

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next = state_reg;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        capture    = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (d_any) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                    // A read and a write at the same time is flagged. The
                    // access still runs, as a write.
                    err_next   = bus.d_rd & bus.d_wr;
                end else if (bus.if_req) begin
                    grant_if   = 1'b1;
                    state_next = BUSY_IF;
                end
            end
            BUSY_D, BUSY_IF: begin
                // If the owner drops its request, flag it once for this
                // transaction. The access still completes.
                if (state_reg == BUSY_D)
                    err_next = ~d_any & ~err_seen_reg;
                else
                    err_next = ~bus.if_req & ~err_seen_reg;
                // The counter holds during the strobe cycle. Because of
                // that, reaching 1 lines up with the cycle in which
                // mem_rdata is valid, MEM_LAT cycles after mem_en.
                if (cnt_reg == 4'd1 && !mem_en_reg) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            owner_d_reg   <= 1'b0;
            err_seen_reg  <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            mem_addr_reg  <= 16'h0000;
            mem_wdata_reg <= 16'h0000;
            if_rdata_reg  <= 16'h0000;
            d_rdata_reg   <= 16'h0000;
            if_done_reg   <= 1'b0;
            d_done_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mem_en_reg   <= grant_d | grant_if;
            if_done_reg  <= capture & ~owner_d_reg;
            d_done_reg   <= capture & owner_d_reg;
            err_reg      <= err_next;
            err_seen_reg <= err_seen_reg | err_next;

            if (grant_d) begin
                mem_addr_reg  <= bus.d_addr;
                mem_wdata_reg <= bus.d_wdata;
                mem_wr_reg    <= bus.d_wr;
                owner_d_reg   <= 1'b1;
                cnt_reg       <= LAT4;
                err_seen_reg  <= 1'b0;
            end else if (grant_if) begin
                // The fetch port has no write data, so mem_wdata keeps its
                // last value.
                mem_addr_reg  <= bus.if_addr;
                mem_wr_reg    <= 1'b0;
                owner_d_reg   <= 1'b0;
                cnt_reg       <= LAT4;
                err_seen_reg  <= 1'b0;
            end else if ((state_reg == BUSY_D || state_reg == BUSY_IF) &&
                         !mem_en_reg && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end

            if (capture && !mem_wr_reg) begin
                if (owner_d_reg)
                    d_rdata_reg <= bus.mem_rdata;
                else
                    if_rdata_reg <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_wr    = mem_wr_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.if_done   = if_done_reg;
    assign bus.d_done    = d_done_reg;
    assign bus.err       = err_reg;

    // Stall drops in the done cycle, so the processor advances on that edge.
    assign bus.stall = (bus.if_req & ~if_done_reg) | (d_any & ~d_done_reg);

endmodule
